// File: rtl/layer_mac_sched.sv
// layer_mac_sched: sequencing controller for one fully-connected layer
// y = ReLU(W*x + b). It streams an N-word vector into the x RAM, then walks
// the shared MAC datapath one row at a time and hands out M results over a
// valid/ready stream. It carries no data, only addresses and strobes.
module layer_mac_sched #(
  parameter int M    = 16,
  parameter int N    = 12,
  parameter int logN = $clog2(N + 1),
  parameter int logM = $clog2(M + 1),
  parameter int logW = $clog2(M * N + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            wr_en_x,
  output logic [logN-1:0] addr_x,
  output logic [logW-1:0] addr_w,
  output logic [logM-1:0] addr_b,
  output logic            bias_ld,
  output logic            acc_en,
  output logic            y_ld,
  output logic            layer_done
);

  typedef enum logic [2:0] {LOAD, BIAS, MAC, DRAIN, CAPT, OUT} state_t;

  localparam logic [logN-1:0] KLAST = logN'(N - 1);
  localparam logic [logN-1:0] DLAST = logN'(1);
  localparam logic [logM-1:0] RLAST = logM'(M - 1);

  state_t          state_q, state_d;
  state_t          st1_q, st2_q;
  logic [logN-1:0] cnt_q, cnt_d;
  logic [logN-1:0] addr_x_q, addr_x_d;
  logic [logM-1:0] row_q, row_d;
  logic [logM-1:0] addr_b_q, addr_b_d;
  logic [logW-1:0] addr_w_q, addr_w_d;
  logic            done_q, done_d;
  logic            in_hs;

  assign in_hs = s_ready & s_valid;

  // State, counters, held addresses and the two-stage state delay line that times the strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      st1_q    <= LOAD;
      st2_q    <= LOAD;
      cnt_q    <= '0;
      row_q    <= '0;
      addr_x_q <= '0;
      addr_b_q <= '0;
      addr_w_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      st1_q    <= state_q;
      st2_q    <= st1_q;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      addr_x_q <= addr_x_d;
      addr_b_q <= addr_b_d;
      addr_w_q <= addr_w_d;
      done_q   <= done_d;
    end
  end

  // Next state; cnt doubles as input count, MAC index k and DRAIN cycle; addresses hold outside their phases
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    addr_w_d = addr_w_q;
    addr_x_d = addr_x_q;
    addr_b_d = addr_b_q;
    done_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (cnt_q == KLAST) begin
            cnt_d   = '0;
            state_d = BIAS;
          end else begin
            cnt_d = cnt_q + logN'(1);
          end
        end
      end
      BIAS: begin
        state_d = MAC;
        if (row_q != '0) addr_w_d = addr_w_q + logW'(1);
      end
      MAC: begin
        if (cnt_q == KLAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d    = cnt_q + logN'(1);
          addr_w_d = addr_w_q + logW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DLAST) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + logN'(1);
        end
      end
      CAPT: state_d = OUT;
      OUT: begin
        if (m_ready) begin
          if (row_q == RLAST) begin
            row_d    = '0;
            addr_w_d = '0;
            done_d   = 1'b1;
            state_d  = LOAD;
          end else begin
            row_d   = row_q + logM'(1);
            state_d = BIAS;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (state_d == LOAD || state_d == MAC) addr_x_d = cnt_d;
    if (state_d == BIAS) addr_b_d = row_d;
  end

  // Outputs: handshakes from current state, accumulator strobes from the delayed state copies
  always_comb begin
    s_ready = (state_q == LOAD) & reset;
    wr_en_x = s_ready & s_valid;
    m_valid = (state_q == OUT);
    y_ld    = (state_q == CAPT);
    bias_ld = (st1_q == BIAS);
    acc_en  = (st2_q == MAC);
  end

  assign addr_x     = addr_x_q;
  assign addr_w     = addr_w_q;
  assign addr_b     = addr_b_q;
  assign layer_done = done_q;

endmodule

// File: tb/tb_layer_mac_sched.sv
// Testbench for layer_mac_sched: a 16x12 instance and a 1x1 instance share
// one clock. A timeline model of each layer (load phase, then per row
// BIAS / N MAC / 2 DRAIN / CAPT / OUT) predicts every output cycle by cycle.
module tb_layer_mac_sched;

  localparam int M0  = 16;
  localparam int N0  = 12;
  localparam int LN0 = $clog2(N0 + 1);
  localparam int LM0 = $clog2(M0 + 1);
  localparam int LW0 = $clog2(M0 * N0 + 1);

  logic clk = 1'b0;
  logic reset;

  logic           sValid0, mReady0, sReady0, mValid0, wrEnX0;
  logic           biasLd0, accEn0, yLd0, layerDone0;
  logic [LN0-1:0] addrX0;
  logic [LW0-1:0] addrW0;
  logic [LM0-1:0] addrB0;

  logic           sValid1, mReady1, sReady1, mValid1, wrEnX1;
  logic           biasLd1, accEn1, yLd1, layerDone1;
  logic [0:0]     addrX1, addrW1, addrB1;

  int   errors = 0;
  int   checks = 0;
  logic sel;
  int   curM, curN;

  logic [31:0] oSready, oWr, oMv, oBl, oAe, oYl, oLd, oAddrX, oAddrW, oAddrB;

  layer_mac_sched #(.M(M0), .N(N0)) dut (
    .clk(clk), .reset(reset), .s_valid(sValid0), .s_ready(sReady0),
    .m_valid(mValid0), .m_ready(mReady0), .wr_en_x(wrEnX0), .addr_x(addrX0),
    .addr_w(addrW0), .addr_b(addrB0), .bias_ld(biasLd0), .acc_en(accEn0),
    .y_ld(yLd0), .layer_done(layerDone0)
  );

  layer_mac_sched #(.M(1), .N(1)) dutSmall (
    .clk(clk), .reset(reset), .s_valid(sValid1), .s_ready(sReady1),
    .m_valid(mValid1), .m_ready(mReady1), .wr_en_x(wrEnX1), .addr_x(addrX1),
    .addr_w(addrW1), .addr_b(addrB1), .bias_ld(biasLd1), .acc_en(accEn1),
    .y_ld(yLd1), .layer_done(layerDone1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Observation view of whichever instance is currently under test
  assign oSready = sel ? 32'(sReady1)    : 32'(sReady0);
  assign oWr     = sel ? 32'(wrEnX1)     : 32'(wrEnX0);
  assign oMv     = sel ? 32'(mValid1)    : 32'(mValid0);
  assign oBl     = sel ? 32'(biasLd1)    : 32'(biasLd0);
  assign oAe     = sel ? 32'(accEn1)     : 32'(accEn0);
  assign oYl     = sel ? 32'(yLd1)       : 32'(yLd0);
  assign oLd     = sel ? 32'(layerDone1) : 32'(layerDone0);
  assign oAddrX  = sel ? 32'(addrX1)     : 32'(addrX0);
  assign oAddrW  = sel ? 32'(addrW1)     : 32'(addrW0);
  assign oAddrB  = sel ? 32'(addrB1)     : 32'(addrB0);

  // One clock cycle: drive inputs just after the edge, return at the falling edge for sampling
  task automatic applyStimulus(input bit sv, input bit mr);
    @(posedge clk);
    #1;
    if (sel) begin
      sValid1 = sv;
      mReady1 = mr;
    end else begin
      sValid0 = sv;
      mReady0 = mr;
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkStrobes(input string ph, input bit sr, input bit wr, input bit mv,
                              input bit bl, input bit ae, input bit yl, input bit ld);
    checkOutput({ph, ".s_ready"}, oSready, 32'(sr));
    checkOutput({ph, ".wr_en_x"}, oWr, 32'(wr));
    checkOutput({ph, ".m_valid"}, oMv, 32'(mv));
    checkOutput({ph, ".bias_ld"}, oBl, 32'(bl));
    checkOutput({ph, ".acc_en"}, oAe, 32'(ae));
    checkOutput({ph, ".y_ld"}, oYl, 32'(yl));
    checkOutput({ph, ".layer_done"}, oLd, 32'(ld));
  endtask

  task automatic checkResetState(input string ph);
    checkStrobes(ph, 0, 0, 0, 0, 0, 0, 0);
    checkOutput({ph, ".addr_x"}, oAddrX, 0);
    checkOutput({ph, ".addr_w"}, oAddrW, 0);
    checkOutput({ph, ".addr_b"}, oAddrB, 0);
  endtask

  // Load phase: every valid word is written at the running count; an optional gap after gapAt words
  task automatic loadVector(input int gapAt, input int gapLen, input bit rnd, input bit expDone);
    int cnt  = 0;
    int idle = 0;
    int cyc  = 0;
    bit sv;
    while (cnt < curN) begin
      if (cnt == gapAt && idle < gapLen) begin
        sv = 1'b0;
        idle++;
      end else if (rnd) begin
        sv = ($urandom_range(0, 3) != 0);
      end else begin
        sv = 1'b1;
      end
      applyStimulus(sv, 1'($urandom_range(0, 1)));
      checkStrobes("load", 1, sv, 0, 0, 0, 0, expDone && (cyc == 0));
      checkOutput("load.addr_x", oAddrX, 32'(cnt));
      if (sv) cnt++;
      cyc++;
    end
  endtask

  // One row: BIAS, then j = 0..N+1 covering N MAC and 2 DRAIN cycles, CAPT, then OUT until accepted
  task automatic rowSeq(input int r, input int stallLen, input bit rnd, input int abortAt);
    int waited = 0;
    bit mr;
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkStrobes("bias", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bias.addr_b", oAddrB, 32'(r));
    for (int j = 0; j < curN + 2; j++) begin
      if (j == abortAt) return;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkStrobes("mac", 0, 0, 0, j == 0, (j >= 2), 0, 0);
      if (j < curN) begin
        checkOutput("mac.addr_x", oAddrX, 32'(j));
        checkOutput("mac.addr_w", oAddrW, 32'(r * curN + j));
      end
    end
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkStrobes("capt", 0, 0, 0, 0, 0, 1, 0);
    do begin
      if (waited < stallLen) mr = 1'b0;
      else if (rnd && waited < stallLen + 30) mr = 1'($urandom_range(0, 1));
      else mr = 1'b1;
      applyStimulus(1'($urandom_range(0, 1)), mr);
      checkStrobes("out", 0, 0, 1, 0, 0, 0, 0);
      checkOutput("out.addr_w", oAddrW, 32'(r * curN + curN - 1));
      waited++;
    end while (!mr);
  endtask

  // Directed sequence of layers on the large instance, then the 1x1 instance
  initial begin
    reset   = 1'b0;
    sel     = 1'b0;
    curM    = M0;
    curN    = N0;
    sValid0 = 1'b1;
    mReady0 = 1'b1;
    sValid1 = 1'b1;
    mReady1 = 1'b1;
    #3;
    checkResetState("reset0");
    sel = 1'b1;
    #1;
    checkResetState("reset1");
    sel = 1'b0;
    sValid0 = 1'b0;
    sValid1 = 1'b0;
    mReady1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Layer A: gapped input, m_ready high except a 10-cycle stall on row 3
    loadVector(5, 3, 1'b0, 1'b0);
    for (int r = 0; r < curM; r++) rowSeq(r, (r == 3) ? 10 : 0, 1'b0, -1);

    // Layer B: random input valid and random output ready
    loadVector(-1, 0, 1'b1, 1'b1);
    for (int r = 0; r < curM; r++) rowSeq(r, 0, 1'b1, -1);

    // Layer C: aborted by reset during row 7 MAC
    loadVector(-1, 0, 1'b1, 1'b1);
    for (int r = 0; r < 7; r++) rowSeq(r, 0, 1'b1, -1);
    rowSeq(7, 0, 1'b1, 4);
    @(posedge clk);
    #2;
    reset   = 1'b0;
    sValid0 = 1'b1;
    #1;
    checkResetState("abort");
    @(posedge clk);
    @(negedge clk);
    sValid0 = 1'b0;
    reset   = 1'b1;

    // Layer D: full fresh vector after the abort, starting again from row 0
    loadVector(-1, 0, 1'b0, 1'b0);
    for (int r = 0; r < curM; r++) rowSeq(r, 0, 1'b1, -1);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("doneA", 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("doneB", 1, 0, 0, 0, 0, 0, 0);

    // 1x1 instance: single-word vectors, second one back-to-back with layer completion
    sValid0 = 1'b0;
    mReady0 = 1'b0;
    sel  = 1'b1;
    curM = 1;
    curN = 1;
    #1;
    loadVector(-1, 0, 1'b0, 1'b0);
    rowSeq(0, 0, 1'b0, -1);
    loadVector(-1, 0, 1'b0, 1'b1);
    rowSeq(0, 2, 1'b1, -1);
    applyStimulus(1'b0, 1'b0);
    checkStrobes("small.done", 1, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
